// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: key sync, go-delay LFSR, BCD reaction timer, display codes.
// Optional best-score memory is built when BEST_SCORE_EN is defined.
module reaction_timer_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_n,
  input  logic       stop_n,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       led_go,
  output logic       busy
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] MAXC = 16'h9999;
  localparam logic [15:0] D_REAC = 16'hAEBC;
  localparam logic [15:0] D_BLNK = 16'hFFFF;
  localparam logic [15:0] D_ERR = 16'hEAAF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_TIMING,
    S_DONE,
    S_CHEAT
  } state_e;

  state_e state_q, state_d;

  logic [1:0] sy1_q, sy1_d;
  logic [1:0] sy2_q, sy2_d;
  logic [1:0] prv_q, prv_d;
  logic [1:0] pls_q, pls_d;
  logic start_p, stop_p;

  logic [15:0] lfsr_q, lfsr_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic tick, entry;
  logic [15:0] dly_q, dly_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0] disp_q, disp_d;
  logic led_q, led_d;
  logic busy_q, busy_d;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Sync flops reset low so a key held through reset never looks like a press.
  always_comb begin
    sy1_d = {stop_n, start_n};
    sy2_d = sy1_q;
    prv_d = sy2_q;
    pls_d = prv_q & ~sy2_q;
  end

  assign start_p = pls_q[0];
  assign stop_p  = pls_q[1];

  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
              lfsr_q[15:1]};
  end

  assign tick    = (tcnt_q == TC);
  assign cnt_inc = bcd_inc(cnt_q);
  assign entry   = (state_d != state_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_p) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stop_p)                      state_d = S_CHEAT;
        else if (tick && dly_q <= 16'd1) state_d = S_TIMING;
      end
      S_TIMING: begin
        if (stop_p)                       state_d = S_DONE;
        else if (tick && cnt_inc == MAXC) state_d = S_DONE;
      end
      S_DONE, S_CHEAT: begin
        if (start_p) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A stop on the same cycle as a tick drops that tick's increment.
  always_comb begin
    tcnt_d = (entry || tick) ? '0 : tcnt_q + CW'(1);
    dly_d  = dly_q;
    cnt_d  = cnt_q;
    if (entry && state_d == S_WAIT)
      dly_d = 16'(MIN_DELAY_MS) + {4'h0, lfsr_q[11:0]};
    else if (state_q == S_WAIT && tick)
      dly_d = dly_q - 16'd1;
    if (entry && state_d == S_TIMING)
      cnt_d = '0;
    else if (state_q == S_TIMING && tick && !stop_p)
      cnt_d = cnt_inc;
  end

`ifdef BEST_SCORE_EN
  logic [15:0] best_q, best_d;
  logic bval_q, bval_d;
  logic show_best;

  always_comb begin
    best_d = best_q;
    bval_d = bval_q;
    if (state_q == S_TIMING && stop_p &&
        (!bval_q || cnt_q < best_q)) begin
      best_d = cnt_q;
      bval_d = 1'b1;
    end
  end

  assign show_best = bval_q && !sy2_q[1] &&
                     (state_q inside {S_IDLE, S_DONE, S_CHEAT});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_q <= MAXC;
      bval_q <= 1'b0;
    end else begin
      best_q <= best_d;
      bval_q <= bval_d;
    end
  end
`endif

  always_comb begin
    disp_d = D_REAC;
    led_d  = 1'b0;
    busy_d = 1'b0;
    unique case (state_q)
      S_IDLE:   disp_d = D_REAC;
      S_WAIT: begin
        disp_d = D_BLNK;
        busy_d = 1'b1;
      end
      S_TIMING: begin
        disp_d = cnt_q;
        led_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_DONE:   disp_d = cnt_q;
      S_CHEAT:  disp_d = D_ERR;
      default:  disp_d = D_REAC;
    endcase
`ifdef BEST_SCORE_EN
    if (show_best) disp_d = best_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sy1_q  <= '0;
      sy2_q  <= '0;
      prv_q  <= '0;
      pls_q  <= '0;
      lfsr_q <= SEED;
      tcnt_q <= '0;
      dly_q  <= '0;
      cnt_q  <= '0;
      disp_q <= D_REAC;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sy1_q  <= sy1_d;
      sy2_q  <= sy2_d;
      prv_q  <= prv_d;
      pls_q  <= pls_d;
      lfsr_q <= lfsr_d;
      tcnt_q <= tcnt_d;
      dly_q  <= dly_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end

  assign digit3 = disp_q[15:12];
  assign digit2 = disp_q[11:8];
  assign digit1 = disp_q[7:4];
  assign digit0 = disp_q[3:0];
  assign led_go = led_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb_reaction_timer_ctrl: randomized game runs checked against a
// cycle-count model of press latency, go delay and tick arithmetic.
module tb_reaction_timer_ctrl;

  localparam int TD  = 2;
  localparam int MIN = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_n = 1'b1;
  logic stop_n = 1'b1;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic led_go, busy;
  logic [15:0] disp;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [15:0] m_lfsr;
  logic [15:0] snap;
  int s, et, ed, exp_n;

  reaction_timer_ctrl #(
    .TICK_DIV(TD),
    .MIN_DELAY_MS(MIN)
  ) dut (
    .clk(clk),
    .reset_n(rst_n),
    .start_n(start_n),
    .stop_n(stop_n),
    .digit3(digit3),
    .digit2(digit2),
    .digit1(digit1),
    .digit0(digit0),
    .led_go(led_go),
    .busy(busy)
  );

  assign disp = {digit3, digit2, digit1, digit0};

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= 0;
      m_lfsr <= 16'hACE1;
    end else begin
      cyc    <= cyc + 1;
      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                 m_lfsr[15:1]};
    end
  end

  function automatic logic [15:0] bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10),
            4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    if (cyc > n) chk("late", cyc, n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic press(input int sp, input logic st, input logic so);
    wait_cyc(sp - 1);
    if (st) start_n = 1'b0;
    if (so) stop_n = 1'b0;
    wait_cyc(sp + 2);
    snap = m_lfsr;
    wait_cyc(sp + 4);
  endtask

  task automatic rel();
    start_n = 1'b1;
    stop_n  = 1'b1;
    wait_cyc(cyc + 4);
  endtask

  task automatic start_run(input string tag, input logic both);
    s = cyc + 1;
    press(s, 1'b1, both);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_blank"}, disp, 16'hFFFF);
    chk({tag, "_led"}, led_go, 0);
    et = s + 3 + (MIN + int'(snap[11:0])) * TD;
    rel();
  endtask

  task automatic finish_run(input string tag, input int r, input int off);
    wait_cyc(et);
    chk({tag, "_pre_go"}, led_go, 0);
    wait_cyc(et + 1);
    chk({tag, "_go"}, led_go, 1);
    wait_cyc(et + TD + 1);
    chk({tag, "_first"}, disp, bcd(1));
    ed = et + r * TD + off;
    exp_n = (ed - et - 1) / TD;
    press(ed - 3, 1'b0, 1'b1);
    chk({tag, "_count"}, disp, bcd(exp_n));
    chk({tag, "_led_off"}, led_go, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_disp", disp, 16'hAEBC);
    chk("rst_led", led_go, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_cyc(5);
    chk("idle_disp", disp, 16'hAEBC);

    start_run("sim_idle", 1'b1);
    finish_run("rnd0", 4 + int'($urandom % 300), int'($urandom % TD));
    wait_cyc(cyc + 6);
    chk("hold_stop_done", disp, bcd(exp_n));
    rel();

    for (int i = 0; i < 2; i++) begin
      start_run("rnd_start", 1'b0);
      finish_run("rnd", 4 + int'($urandom % 2000), int'($urandom % TD));
      rel();
    end

    start_run("norm", 1'b0);
    finish_run("norm", 247, 1);
    chk("norm_0247", disp, 16'h0247);
    rel();

    start_run("early", 1'b0);
    ed = cyc + 8 + int'($urandom % (et - cyc - 8));
    press(ed - 3, 1'b0, 1'b1);
    chk("early_disp", disp, 16'hEAAF);
    chk("early_busy", busy, 0);
    chk("early_led", led_go, 0);
    rel();

    start_run("coin", 1'b0);
    press(et - 3, 1'b0, 1'b1);
    chk("coin_disp", disp, 16'hEAAF);
    chk("coin_led", led_go, 0);
    rel();

    start_run("simw", 1'b0);
    press(cyc + 1, 1'b1, 1'b1);
    chk("simw_disp", disp, 16'hEAAF);
    chk("simw_busy", busy, 0);
    rel();

    start_run("sat", 1'b0);
    wait_cyc(et + 1);
    chk("sat_go", led_go, 1);
    wait_cyc(et + 9998 * TD + 1);
    chk("sat_9998", disp, bcd(9998));
    chk("sat_led_on", led_go, 1);
    wait_cyc(et + 9999 * TD + 1);
    chk("sat_9999", disp, 16'h9999);
    chk("sat_led_off", led_go, 0);
    chk("sat_busy", busy, 0);
    wait_cyc(cyc + 3 * TD);
    chk("sat_hold", disp, 16'h9999);

    start_run("rstm", 1'b0);
    wait_cyc(cyc + 10);
    chk("rstm_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstm_disp", disp, 16'hAEBC);
    chk("rstm_busy0", busy, 0);
    start_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(10);
    chk("held_key_busy", busy, 0);
    chk("held_key_disp", disp, 16'hAEBC);
    start_n = 1'b1;
    wait_cyc(cyc + 5);
    start_run("post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
